// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder/subtractor that processes CHUNK bits per clock, LSB chunk first.
// WIDTH must be a multiple of CHUNK; the result appears after N = WIDTH/CHUNK RUN cycles.
module seq_chunk_adder #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             ready,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned N  = WIDTH / CHUNK;
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_r, b_r, acc, acc_nx;
  logic             carry, a_msb, b_msb;
  logic [IW-1:0]    idx;
  logic             last;
  logic [CHUNK:0]   csum;

  // Operands shift right each RUN cycle so the active chunk is always at bit 0;
  // the accumulator fills from the top so it is aligned after the last chunk.
  always_comb begin
    csum   = {1'b0, a_r[CHUNK-1:0]} + {1'b0, b_r[CHUNK-1:0]} + (CHUNK+1)'(carry);
    acc_nx = (acc >> CHUNK) | (WIDTH'(csum[CHUNK-1:0]) << (WIDTH - CHUNK));
    last   = (idx == IW'(N - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last)  state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they track state exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready <= 1'b1;
      busy  <= 1'b0;
      valid <= 1'b0;
    end else begin
      ready <= (state_nx == IDLE);
      busy  <= (state_nx == RUN);
      valid <= (state_nx == DONE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r   <= '0;
      b_r   <= '0;
      acc   <= '0;
      carry <= 1'b0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_r   <= a;
            b_r   <= sub ? ~b : b;
            carry <= sub | cin;
            a_msb <= a[WIDTH-1];
            b_msb <= sub ? ~b[WIDTH-1] : b[WIDTH-1];
            acc   <= '0;
            idx   <= '0;
          end
        end
        RUN: begin
          a_r   <= a_r >> CHUNK;
          b_r   <= b_r >> CHUNK;
          acc   <= acc_nx;
          carry <= csum[CHUNK];
          idx   <= idx + 1'b1;
          if (last) begin
            sum  <= acc_nx;
            cout <= csum[CHUNK];
            ovf  <= (a_msb == b_msb) && (acc_nx[WIDTH-1] != a_msb);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
